lock_monitor: RTL and testbench

LOCK_MONITOR -- requirements
Module: lock_monitor

---
 rtl/lock_monitor_if.sv | 45 ++++
 rtl/lock_monitor.sv | 224 ++++++++++++++++++++++
 tb/tb_lock_monitor.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/lock_monitor_if.sv
`default_nettype none
// ============================================================================
// Module      : lock_monitor_if
// Description : Bundles the measurement controls, configuration and status
//               signals of lock_monitor.
//               master : drives enable/events/configuration, observes status
//               slave  : the monitor itself
//               enable, freqUp, freqDn, windowLen, lockThreshold, lockCount,
//               unlockCount, clearLossFlag                  (master -> slave)
//               locked, state, lossOfLock, lastError, windowDone
//                                                           (slave -> master)
// Revision    : 1.0 - initial release
// ============================================================================
interface lock_monitor_if #(
    parameter int CNT_W  = 6,
    parameter int WIN_W  = 8,
    parameter int CONF_W = 3
);
    logic              enable;
    logic              freqUp;
    logic              freqDn;
    logic [WIN_W-1:0]  windowLen;
    logic [CNT_W-1:0]  lockThreshold;
    logic [CONF_W-1:0] lockCount;
    logic [CONF_W-1:0] unlockCount;
    logic              clearLossFlag;
    logic              locked;
    logic [1:0]        state;
    logic              lossOfLock;
    logic [CNT_W-1:0]  lastError;
    logic              windowDone;

    modport master (
        output enable, freqUp, freqDn, windowLen, lockThreshold,
               lockCount, unlockCount, clearLossFlag,
        input  locked, state, lossOfLock, lastError, windowDone
    );

    modport slave (
        input  enable, freqUp, freqDn, windowLen, lockThreshold,
               lockCount, unlockCount, clearLossFlag,
        output locked, state, lossOfLock, lastError, windowDone
    );
endinterface
`default_nettype wire

// File: rtl/lock_monitor.sv
`default_nettype none
// ============================================================================
// Module      : lock_monitor
// Description : Windowed PLL lock detector. Counts phase/frequency-detector
//               up/down events over windows of windowLen+1 enabled cycles,
//               grades each closed window as good (|up-dn| within threshold,
//               no counter saturation) or bad, and runs a hysteresis FSM
//               UNLOCKED -> ACQUIRING -> LOCKED -> LOSING that requires
//               lockCount consecutive good windows to lock and unlockCount
//               consecutive bad windows to unlock.
// Ports       : clock  - rising-edge clock
//               reset  - synchronous active-high reset
//               bus    - lock_monitor_if.slave (enable, freqUp, freqDn,
//                        windowLen, lockThreshold, lockCount, unlockCount,
//                        clearLossFlag in; locked, state, lossOfLock,
//                        lastError, windowDone out)
// Revision    : 1.0 - initial release
// ============================================================================
module lock_monitor #(
    parameter int CNT_W  = 6,
    parameter int WIN_W  = 8,
    parameter int CONF_W = 3
) (
    input  wire logic     clock,
    input  wire logic     reset,
    lock_monitor_if.slave bus
);

    typedef enum logic [1:0] {
        c_UNLOCKED  = 2'd0,
        c_ACQUIRING = 2'd1,
        c_LOCKED    = 2'd2,
        c_LOSING    = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0]  c_CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0]  c_CNT_ONE  = CNT_W'(1);
    localparam logic [WIN_W-1:0]  c_WIN_ONE  = WIN_W'(1);
    localparam logic [CONF_W-1:0] c_CONF_MAX = {CONF_W{1'b1}};
    localparam logic [CONF_W-1:0] c_CONF_ONE = CONF_W'(1);

    // Registered state
    state_t            r_state;
    logic [WIN_W-1:0]  r_win_cnt;
    logic [CNT_W-1:0]  r_up_cnt;
    logic [CNT_W-1:0]  r_dn_cnt;
    logic [CONF_W-1:0] r_good_cnt;
    logic [CONF_W-1:0] r_bad_cnt;
    logic [CNT_W-1:0]  r_last_error;
    logic              r_loss;
    logic              r_window_done;

    // Combinational
    logic              w_closing;
    logic [CNT_W-1:0]  w_up_next;
    logic [CNT_W-1:0]  w_dn_next;
    logic              w_up_sat;
    logic              w_dn_sat;
    logic [CNT_W-1:0]  w_error;
    logic              w_good;
    logic [CONF_W-1:0] w_lock_need;
    logic [CONF_W-1:0] w_unlock_need;
    logic [CONF_W-1:0] w_good_inc;
    logic [CONF_W-1:0] w_bad_inc;
    state_t            w_state_next;
    logic [CONF_W-1:0] w_good_next;
    logic [CONF_W-1:0] w_bad_next;
    logic              w_loss_set;

    // ------------------------------------------------------------------------
    // Window bookkeeping
    // ------------------------------------------------------------------------
    assign w_closing = bus.enable && (r_win_cnt == bus.windowLen);

    // Counts including this cycle's events: in the closing cycle these are
    // the final window totals, otherwise they are the next register values.
    assign w_up_next = (bus.freqUp && (r_up_cnt != c_CNT_MAX)) ? r_up_cnt + c_CNT_ONE : r_up_cnt;
    assign w_dn_next = (bus.freqDn && (r_dn_cnt != c_CNT_MAX)) ? r_dn_cnt + c_CNT_ONE : r_dn_cnt;

    // A counter sitting at all-ones may have lost events, so its window
    // cannot be trusted regardless of the computed error.
    assign w_up_sat = (w_up_next == c_CNT_MAX);
    assign w_dn_sat = (w_dn_next == c_CNT_MAX);

    // Both operands are unsigned CNT_W values, so the magnitude always fits.
    assign w_error = (w_up_next >= w_dn_next) ? (w_up_next - w_dn_next)
                                              : (w_dn_next - w_up_next);

    assign w_good = !w_up_sat && !w_dn_sat && (w_error <= bus.lockThreshold);

    // A zero confirmation count would otherwise never be reached.
    assign w_lock_need   = (bus.lockCount   == '0) ? c_CONF_ONE : bus.lockCount;
    assign w_unlock_need = (bus.unlockCount == '0) ? c_CONF_ONE : bus.unlockCount;

    assign w_good_inc = (r_good_cnt != c_CONF_MAX) ? r_good_cnt + c_CONF_ONE : r_good_cnt;
    assign w_bad_inc  = (r_bad_cnt  != c_CONF_MAX) ? r_bad_cnt  + c_CONF_ONE : r_bad_cnt;

    // ------------------------------------------------------------------------
    // Lock FSM: next state, evaluated only on window close
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        w_good_next  = r_good_cnt;
        w_bad_next   = r_bad_cnt;
        if (w_closing) begin
            case (r_state)
                c_UNLOCKED: begin
                    if (w_good) begin
                        if (w_lock_need == c_CONF_ONE) begin
                            w_state_next = c_LOCKED;
                            w_good_next  = '0;
                        end else begin
                            w_state_next = c_ACQUIRING;
                            w_good_next  = c_CONF_ONE;
                        end
                    end
                end
                c_ACQUIRING: begin
                    if (w_good) begin
                        if (w_good_inc >= w_lock_need) begin
                            w_state_next = c_LOCKED;
                            w_good_next  = '0;
                        end else begin
                            w_good_next  = w_good_inc;
                        end
                    end else begin
                        w_state_next = c_UNLOCKED;
                        w_good_next  = '0;
                    end
                end
                c_LOCKED: begin
                    if (w_good) begin
                        w_bad_next = '0;
                    end else if (w_unlock_need == c_CONF_ONE) begin
                        w_state_next = c_UNLOCKED;
                        w_bad_next   = '0;
                    end else begin
                        w_state_next = c_LOSING;
                        w_bad_next   = c_CONF_ONE;
                    end
                end
                c_LOSING: begin
                    if (w_good) begin
                        w_state_next = c_LOCKED;
                        w_bad_next   = '0;
                    end else if (w_bad_inc >= w_unlock_need) begin
                        w_state_next = c_UNLOCKED;
                        w_bad_next   = '0;
                    end else begin
                        w_bad_next   = w_bad_inc;
                    end
                end
                default: begin
                    w_state_next = c_UNLOCKED;
                    w_good_next  = '0;
                    w_bad_next   = '0;
                end
            endcase
        end
    end

    // Losing lock is any exit from the locked pair back to UNLOCKED.
    assign w_loss_set = w_closing
                     && ((r_state == c_LOCKED) || (r_state == c_LOSING))
                     && (w_state_next == c_UNLOCKED);

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state       <= c_UNLOCKED;
            r_win_cnt     <= '0;
            r_up_cnt      <= '0;
            r_dn_cnt      <= '0;
            r_good_cnt    <= '0;
            r_bad_cnt     <= '0;
            r_last_error  <= '0;
            r_loss        <= 1'b0;
            r_window_done <= 1'b0;
        end else begin
            r_window_done <= 1'b0;
            // w_state_next/good/bad equal the current values unless closing.
            r_state       <= w_state_next;
            r_good_cnt    <= w_good_next;
            r_bad_cnt     <= w_bad_next;

            if (!bus.enable) begin
                // Disabled: the partial window is discarded.
                r_win_cnt <= '0;
                r_up_cnt  <= '0;
                r_dn_cnt  <= '0;
            end else if (w_closing) begin
                r_win_cnt     <= '0;
                r_up_cnt      <= '0;
                r_dn_cnt      <= '0;
                r_window_done <= 1'b1;
                r_last_error  <= w_error;
            end else begin
                r_win_cnt <= r_win_cnt + c_WIN_ONE;
                r_up_cnt  <= w_up_next;
                r_dn_cnt  <= w_dn_next;
            end

            // A fresh loss event must not be swallowed by a concurrent clear.
            if (w_loss_set) begin
                r_loss <= 1'b1;
            end else if (bus.clearLossFlag) begin
                r_loss <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign bus.state      = r_state;
    assign bus.locked     = (r_state == c_LOCKED) || (r_state == c_LOSING);
    assign bus.lossOfLock = r_loss;
    assign bus.lastError  = r_last_error;
    assign bus.windowDone = r_window_done;

endmodule
`default_nettype wire

// File: tb/tb_lock_monitor.sv
`default_nettype none
// ============================================================================
// Module      : tb_lock_monitor
// Description : Directed self-checking bench for lock_monitor. One DUT with
//               default widths, one with CNT_W=4 for counter saturation.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lock_monitor;

    logic clock;
    logic reset;
    int   n_vec;
    int   n_err;

    lock_monitor_if #(.CNT_W(6), .WIN_W(8), .CONF_W(3)) bus ();
    lock_monitor_if #(.CNT_W(4), .WIN_W(8), .CONF_W(3)) bus4 ();

    lock_monitor #(.CNT_W(6), .WIN_W(8), .CONF_W(3)) u_dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    lock_monitor #(.CNT_W(4), .WIN_W(8), .CONF_W(3)) u_dut4 (
        .clock (clock),
        .reset (reset),
        .bus   (bus4)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Inputs change and outputs are sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // One full window of windowLen+1 enabled cycles on the default DUT.
    // freqUp on the first n_up cycles and freqDn on the first n_dn cycles,
    // or alternating up/down when alt is set. clr_last raises clearLossFlag
    // in the closing cycle. Reports how many windowDone pulses were seen and
    // the cycle index of the first one.
    task automatic run_window(input int n_up, input int n_dn, input bit alt,
                              input bit clr_last, output int done_cnt,
                              output int done_at);
        int len;
        len      = int'(bus.windowLen);
        done_cnt = 0;
        done_at  = -1;
        for (int i = 0; i <= len; i++) begin
            if (alt) begin
                bus.freqUp = (i % 2 == 0);
                bus.freqDn = (i % 2 == 1);
            end else begin
                bus.freqUp = (i < n_up);
                bus.freqDn = (i < n_dn);
            end
            bus.clearLossFlag = clr_last && (i == len);
            tick();
            if (bus.windowDone === 1'b1) begin
                done_cnt++;
                if (done_at < 0) done_at = i;
            end
        end
        bus.freqUp        = 1'b0;
        bus.freqDn        = 1'b0;
        bus.clearLossFlag = 1'b0;
    endtask

    // Drop enable for one cycle so the next window starts from a clean count.
    task automatic realign();
        bus.enable = 1'b0;
        tick();
        bus.enable = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.enable = 1'b1; bus.freqUp = 1'b1; bus.clearLossFlag = 1'b1;
        tick(); tick();
        n_vec++; if (bus.state !== 2'd0) begin n_err++; $display("FAIL reset_state: got %0d expected 0", bus.state); end
        n_vec++; if (bus.locked !== 1'b0) begin n_err++; $display("FAIL reset_locked: got %0b expected 0", bus.locked); end
        n_vec++; if (bus.lossOfLock !== 1'b0) begin n_err++; $display("FAIL reset_loss: got %0b expected 0", bus.lossOfLock); end
        n_vec++; if (bus.lastError !== 6'd0) begin n_err++; $display("FAIL reset_lasterr: got %0d expected 0", bus.lastError); end
        n_vec++; if (bus.windowDone !== 1'b0) begin n_err++; $display("FAIL reset_done: got %0b expected 0", bus.windowDone); end
        reset = 1'b0;
        bus.enable = 1'b0; bus.freqUp = 1'b0; bus.clearLossFlag = 1'b0;
        tick();
    endtask

    // Three good windows with lockCount=3: ACQUIRING, ACQUIRING, LOCKED.
    task automatic test_acquire();
        int dc, da;
        logic [1:0] exp_state [3];
        logic       exp_lock  [3];
        exp_state = '{2'd1, 2'd1, 2'd2};
        exp_lock  = '{1'b0, 1'b0, 1'b1};
        bus.windowLen = 8'd15; bus.lockThreshold = 6'd2;
        bus.lockCount = 3'd3;  bus.unlockCount   = 3'd2;
        bus.enable = 1'b1;
        for (int w = 0; w < 3; w++) begin
            run_window(0, 0, 1'b1, 1'b0, dc, da);
            n_vec++; if (dc !== 1 || da !== 15) begin n_err++; $display("FAIL acq_done_w%0d: got %0d pulses at %0d expected 1 at 15", w, dc, da); end
            n_vec++; if (bus.state !== exp_state[w]) begin n_err++; $display("FAIL acq_state_w%0d: got %0d expected %0d", w, bus.state, exp_state[w]); end
            n_vec++; if (bus.locked !== exp_lock[w]) begin n_err++; $display("FAIL acq_locked_w%0d: got %0b expected %0b", w, bus.locked, exp_lock[w]); end
        end
        n_vec++; if (bus.lastError !== 6'd0) begin n_err++; $display("FAIL acq_lasterr: got %0d expected 0", bus.lastError); end
    endtask

    // From LOCKED, two all-up windows with unlockCount=2.
    task automatic test_unlock();
        int dc, da;
        run_window(16, 0, 1'b0, 1'b0, dc, da);
        n_vec++; if (bus.state !== 2'd3) begin n_err++; $display("FAIL unl1_state: got %0d expected 3", bus.state); end
        n_vec++; if (bus.locked !== 1'b1) begin n_err++; $display("FAIL unl1_locked: got %0b expected 1", bus.locked); end
        n_vec++; if (bus.lastError !== 6'd16) begin n_err++; $display("FAIL unl1_lasterr: got %0d expected 16", bus.lastError); end
        n_vec++; if (bus.lossOfLock !== 1'b0) begin n_err++; $display("FAIL unl1_loss: got %0b expected 0", bus.lossOfLock); end
        run_window(16, 0, 1'b0, 1'b0, dc, da);
        n_vec++; if (bus.state !== 2'd0) begin n_err++; $display("FAIL unl2_state: got %0d expected 0", bus.state); end
        n_vec++; if (bus.locked !== 1'b0) begin n_err++; $display("FAIL unl2_locked: got %0b expected 0", bus.locked); end
        n_vec++; if (bus.lossOfLock !== 1'b1) begin n_err++; $display("FAIL unl2_loss: got %0b expected 1", bus.lossOfLock); end
    endtask

    task automatic test_clear_loss();
        bus.clearLossFlag = 1'b1;
        tick();
        bus.clearLossFlag = 1'b0;
        n_vec++; if (bus.lossOfLock !== 1'b0) begin n_err++; $display("FAIL clr_loss: got %0b expected 0", bus.lossOfLock); end
        realign();
    endtask

    // Lock, then one bad window (error 3 > 2) and good windows (error 2 == 2).
    task automatic test_recover();
        int dc, da;
        bus.lockCount = 3'd3; bus.unlockCount = 3'd2;
        for (int w = 0; w < 3; w++) run_window(0, 0, 1'b1, 1'b0, dc, da);
        n_vec++; if (bus.state !== 2'd2) begin n_err++; $display("FAIL rec_lock: got %0d expected 2", bus.state); end
        run_window(3, 0, 1'b0, 1'b0, dc, da);
        n_vec++; if (bus.state !== 2'd3) begin n_err++; $display("FAIL rec_bad_state: got %0d expected 3", bus.state); end
        n_vec++; if (bus.locked !== 1'b1) begin n_err++; $display("FAIL rec_bad_locked: got %0b expected 1", bus.locked); end
        n_vec++; if (bus.lastError !== 6'd3) begin n_err++; $display("FAIL rec_bad_lasterr: got %0d expected 3", bus.lastError); end
        run_window(2, 0, 1'b0, 1'b0, dc, da);
        n_vec++; if (bus.state !== 2'd2) begin n_err++; $display("FAIL rec_good_state: got %0d expected 2", bus.state); end
        n_vec++; if (bus.lastError !== 6'd2) begin n_err++; $display("FAIL rec_good_lasterr: got %0d expected 2", bus.lastError); end
        run_window(0, 2, 1'b0, 1'b0, dc, da);
        n_vec++; if (bus.state !== 2'd2 || bus.locked !== 1'b1) begin n_err++; $display("FAIL rec_hold: got state %0d locked %0b expected 2 1", bus.state, bus.locked); end
        n_vec++; if (bus.lossOfLock !== 1'b0) begin n_err++; $display("FAIL rec_loss: got %0b expected 0", bus.lossOfLock); end
    endtask

    // unlockCount=0 acts as 1; clear in the unlocking closing cycle loses.
    task automatic test_loss_priority();
        int dc, da;
        bus.unlockCount = 3'd0;
        run_window(16, 0, 1'b0, 1'b1, dc, da);
        n_vec++; if (bus.state !== 2'd0) begin n_err++; $display("FAIL prio_state: got %0d expected 0", bus.state); end
        n_vec++; if (bus.lossOfLock !== 1'b1) begin n_err++; $display("FAIL prio_loss_set: got %0b expected 1", bus.lossOfLock); end
        bus.clearLossFlag = 1'b1;
        tick();
        bus.clearLossFlag = 1'b0;
        n_vec++; if (bus.lossOfLock !== 1'b0) begin n_err++; $display("FAIL prio_loss_clr: got %0b expected 0", bus.lossOfLock); end
        realign();
    endtask

    // lockCount=0 acts as 1: a single good window locks from UNLOCKED.
    task automatic test_fast_lock();
        int dc, da;
        bus.lockCount = 3'd0;
        run_window(0, 0, 1'b1, 1'b0, dc, da);
        n_vec++; if (bus.state !== 2'd2) begin n_err++; $display("FAIL fast_lock: got %0d expected 2", bus.state); end
        realign();
    endtask

    // Abort at window count 10 with up events pending, then a fresh window.
    task automatic test_abort();
        int dc, da, seen;
        bus.freqUp = 1'b1;
        for (int i = 0; i < 10; i++) tick();
        bus.freqUp = 1'b0;
        bus.enable = 1'b0;
        seen = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (bus.windowDone === 1'b1) seen++;
        end
        n_vec++; if (seen !== 0) begin n_err++; $display("FAIL abort_done: got %0d pulses expected 0", seen); end
        n_vec++; if (bus.state !== 2'd2) begin n_err++; $display("FAIL abort_state_held: got %0d expected 2", bus.state); end
        bus.enable = 1'b1;
        run_window(0, 0, 1'b1, 1'b0, dc, da);
        n_vec++; if (dc !== 1 || da !== 15) begin n_err++; $display("FAIL abort_next_done: got %0d pulses at %0d expected 1 at 15", dc, da); end
        n_vec++; if (bus.lastError !== 6'd0) begin n_err++; $display("FAIL abort_lasterr: got %0d expected 0", bus.lastError); end
        n_vec++; if (bus.state !== 2'd2) begin n_err++; $display("FAIL abort_state: got %0d expected 2", bus.state); end
    endtask

    // Reset in the middle of a window, with loss and lastError non-zero.
    task automatic test_reset_mid();
        int dc, da;
        bus.unlockCount = 3'd1;
        run_window(5, 0, 1'b0, 1'b0, dc, da);
        n_vec++; if (bus.lossOfLock !== 1'b1 || bus.lastError !== 6'd5) begin n_err++; $display("FAIL rmid_pre: got loss %0b err %0d expected 1 5", bus.lossOfLock, bus.lastError); end
        bus.freqUp = 1'b1;
        for (int i = 0; i < 6; i++) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        bus.freqUp = 1'b0;
        n_vec++; if (bus.state !== 2'd0 || bus.locked !== 1'b0) begin n_err++; $display("FAIL rmid_state: got %0d locked %0b expected 0 0", bus.state, bus.locked); end
        n_vec++; if (bus.lossOfLock !== 1'b0) begin n_err++; $display("FAIL rmid_loss: got %0b expected 0", bus.lossOfLock); end
        n_vec++; if (bus.lastError !== 6'd0) begin n_err++; $display("FAIL rmid_lasterr: got %0d expected 0", bus.lastError); end
        n_vec++; if (bus.windowDone !== 1'b0) begin n_err++; $display("FAIL rmid_done: got %0b expected 0", bus.windowDone); end
        bus.lockCount = 3'd3;
        run_window(0, 0, 1'b1, 1'b0, dc, da);
        n_vec++; if (dc !== 1 || da !== 15) begin n_err++; $display("FAIL rmid_next_done: got %0d pulses at %0d expected 1 at 15", dc, da); end
        n_vec++; if (bus.state !== 2'd1 || bus.lastError !== 6'd0) begin n_err++; $display("FAIL rmid_next: got state %0d err %0d expected 1 0", bus.state, bus.lastError); end
        bus.enable = 1'b0;
    endtask

    // CNT_W=4 with 32-cycle windows: counters saturate at 15.
    task automatic test_saturate();
        int dc, da;
        bus4.windowLen = 8'd31; bus4.lockThreshold = 4'd2;
        bus4.lockCount = 3'd3;  bus4.unlockCount   = 3'd2;
        bus4.clearLossFlag = 1'b0;
        bus4.enable = 1'b1;
        bus4.freqUp = 1'b1; bus4.freqDn = 1'b1;
        dc = 0; da = -1;
        for (int i = 0; i < 32; i++) begin
            tick();
            if (bus4.windowDone === 1'b1) begin dc++; if (da < 0) da = i; end
        end
        n_vec++; if (dc !== 1 || da !== 31) begin n_err++; $display("FAIL sat_done: got %0d pulses at %0d expected 1 at 31", dc, da); end
        n_vec++; if (bus4.lastError !== 4'd0) begin n_err++; $display("FAIL sat_both_err: got %0d expected 0", bus4.lastError); end
        n_vec++; if (bus4.state !== 2'd0) begin n_err++; $display("FAIL sat_both_state: got %0d expected 0", bus4.state); end
        bus4.freqDn = 1'b0;
        for (int i = 0; i < 32; i++) tick();
        n_vec++; if (bus4.lastError !== 4'd15) begin n_err++; $display("FAIL sat_up_err: got %0d expected 15", bus4.lastError); end
        n_vec++; if (bus4.state !== 2'd0) begin n_err++; $display("FAIL sat_up_state: got %0d expected 0", bus4.state); end
        bus4.freqUp = 1'b0;
        bus4.enable = 1'b0;
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        reset = 1'b1;
        bus.enable = 1'b0; bus.freqUp = 1'b0; bus.freqDn = 1'b0;
        bus.windowLen = 8'd15; bus.lockThreshold = 6'd2;
        bus.lockCount = 3'd3; bus.unlockCount = 3'd2; bus.clearLossFlag = 1'b0;
        bus4.enable = 1'b0; bus4.freqUp = 1'b0; bus4.freqDn = 1'b0;
        bus4.windowLen = 8'd31; bus4.lockThreshold = 4'd2;
        bus4.lockCount = 3'd3; bus4.unlockCount = 3'd2; bus4.clearLossFlag = 1'b0;
        tick(); tick();

        test_reset();
        test_acquire();
        test_unlock();
        test_clear_loss();
        test_recover();
        test_loss_priority();
        test_fast_lock();
        test_abort();
        test_reset_mid();
        test_saturate();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
